decoder_grant_scheduler: RTL and testbench

- Round-robin scheduler that shares the 3-to-8 one-hot decoder/LED bank among 8 requesters.
- Picks one requester and drives the decoder select lines for it, plus a matching registered one-hot grant.
- Holds the grant for a minimum time, releases on `done`, and inserts a one-cycle break-before-make gap.
- Sits between request sources (switch logic, test sequencers) and the decoder datapath.

---
 rtl/decoder_grant_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_decoder_grant_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_grant_scheduler.sv
// -----------------------------------------------------------------------------
// decoder_grant_scheduler
//
// Round-robin scheduler that shares the 3-to-8 one-hot decoder / LED bank
// among 8 requesters. One requester is picked at a time. The scheduler drives
// the decoder select lines for that requester and a matching registered
// one-hot grant. The grant is held for a minimum time and released on `done`
// (or when the holder drops its request). A one-cycle break-before-make gap
// follows every release.
//
// Parameters:
//   MIN_HOLD  : minimum cycles a grant stays asserted before a release is
//               honoured (0 behaves as 1).
//   MAX_GRANT : watchdog limit in cycles, legal range 1..255. It is used only
//               when the WATCHDOG_EN macro is defined.
//
// Optional feature (macro WATCHDOG_EN):
//   defined   : a grant that reaches MAX_GRANT cycles without a release is
//               forced off. timeout pulses for the GAP cycle that follows.
//   undefined : no watchdog logic; timeout is constant 0.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   enable   in   1 = new grants allowed, 0 = finish current grant only
//   req[7:0] in   request vector, bit i = requester i
//   done     in   holder finished (level, sampled only in GRANT)
//   sel[2:0] out  decoder select = index of current/last holder
//   grant    out  registered one-hot grant, 0 outside GRANT
//   busy     out  1 while in GRANT
//   timeout  out  one-cycle pulse on watchdog release
//
// Handshake: a requester holds req[i] high until it sees grant[i]. It may
// then signal completion with done, or by dropping req[i]. Either is
// honoured only once the minimum hold time has elapsed.
// -----------------------------------------------------------------------------
module decoder_grant_scheduler #(
    parameter int unsigned MIN_HOLD  = 2,
    parameter int unsigned MAX_GRANT = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // A MIN_HOLD of 0 is treated as 1. Values above 255 are clamped to the
    // 8-bit counter range.
    localparam int unsigned HOLD_MIN_I =
        (MIN_HOLD == 0) ? 1 : ((MIN_HOLD > 255) ? 255 : MIN_HOLD);
    localparam logic [7:0] HOLD_MIN = HOLD_MIN_I[7:0];

    if (MAX_GRANT < 1 || MAX_GRANT > 255) begin : g_max_grant_range
        $error("decoder_grant_scheduler: MAX_GRANT must be in 1..255");
    end

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic [2:0] last_q, last_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       hold_met;
    logic       release_req;
    logic       wd_fire;

    // Rotating priority search. It starts one past the last holder, so the
    // previous holder is checked last. Offset 8 wraps to last_q itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            cand = last_q + 3'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign hold_met    = (hold_cnt_q >= HOLD_MIN);
    assign release_req = done || !req[sel_q];

`ifdef WATCHDOG_EN
    localparam logic [8:0] WD_LIMIT = MAX_GRANT[8:0];
    // The watchdog fires on the edge where the counter would reach MAX_GRANT.
    // As a result, the grant is visible for MAX_GRANT-1 cycles.
    assign wd_fire = (state_q == S_GRANT) &&
                     (({1'b0, hold_cnt_q} + 9'd1) >= WD_LIMIT);
`else
    assign wd_fire = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && win_found) begin
                    sel_d      = win_idx;
                    grant_d    = 8'd1 << win_idx;
                    busy_d     = 1'b1;
                    hold_cnt_d = 8'd1;
                    last_d     = win_idx;
                    state_d    = S_GRANT;
                end
            end
            S_GRANT: begin
                if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                // Watchdog wins over a coincident done.
                if (wd_fire) begin
                    grant_d   = 8'd0;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = S_GAP;
                end else if (release_req && hold_met) begin
                    grant_d = 8'd0;
                    busy_d  = 1'b0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                grant_d = 8'd0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= 3'd0;
            grant_q    <= 8'd0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            last_q     <= 3'd7;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_decoder_grant_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for decoder_grant_scheduler.
// Instance dut  : MIN_HOLD=2, MAX_GRANT=10.
// Instance dut4 : MIN_HOLD=4, used for the continuous-done hold test.
// -----------------------------------------------------------------------------
module tb_decoder_grant_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       busy;
    logic       timeout;

    logic [7:0] req4;
    logic       done4;
    logic [2:0] sel4;
    logic [7:0] grant4;
    logic       busy4;
    logic       timeout4;

    int pass_cnt;
    int total_cnt;

    decoder_grant_scheduler #(.MIN_HOLD(2), .MAX_GRANT(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .req    (req),
        .done   (done),
        .sel    (sel),
        .grant  (grant),
        .busy   (busy),
        .timeout(timeout)
    );

    decoder_grant_scheduler #(.MIN_HOLD(4), .MAX_GRANT(10)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .req    (req4),
        .done   (done4),
        .sel    (sel4),
        .grant  (grant4),
        .busy   (busy4),
        .timeout(timeout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        req    = 8'h00;
        done   = 1'b0;
        req4   = 8'h00;
        done4  = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({busy, sel, grant, timeout} !== 13'd0) begin
            $display("FAIL reset_state got busy=%b sel=%0d grant=%h timeout=%b exp all 0",
                     busy, sel, grant, timeout);
        end else pass_cnt++;
        total_cnt++;
        if ({busy4, grant4} !== 9'd0) begin
            $display("FAIL reset_state4 got busy=%b grant=%h exp 0", busy4, grant4);
        end else pass_cnt++;
    endtask

    task automatic test_idle();
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total_cnt++;
            if ({busy, sel, grant} !== 12'd0) begin
                $display("FAIL idle_c%0d got busy=%b sel=%0d grant=%h exp 0", c, busy, sel, grant);
            end else pass_cnt++;
        end
    endtask

    // req=24: holders alternate 2,5,2 with done at hold_cnt=3.
    task automatic test_round_robin_pair();
        logic [2:0] exp_sel;
        logic [7:0] exp_gnt;
        do_reset();
        enable = 1'b1;
        req    = 8'h24;
        tick();
        for (int k = 0; k < 3; k++) begin
            exp_sel = (k % 2 == 0) ? 3'd2 : 3'd5;
            exp_gnt = (k % 2 == 0) ? 8'h04 : 8'h20;
            for (int h = 1; h <= 3; h++) begin
                total_cnt++;
                if ({busy, sel, grant} !== {1'b1, exp_sel, exp_gnt}) begin
                    $display("FAIL rr_k%0d_h%0d got busy=%b sel=%0d grant=%h exp busy=1 sel=%0d grant=%h",
                             k, h, busy, sel, grant, exp_sel, exp_gnt);
                end else pass_cnt++;
                if (h == 3) done = 1'b1;
                tick();
            end
            done = 1'b0;
            total_cnt++;
            if ({busy, sel, grant} !== {1'b0, exp_sel, 8'h00}) begin
                $display("FAIL rr_gap_k%0d got busy=%b sel=%0d grant=%h exp busy=0 sel=%0d grant=00",
                         k, busy, sel, grant, exp_sel);
            end else pass_cnt++;
            tick();
            total_cnt++;
            if ({busy, sel, grant} !== {1'b0, exp_sel, 8'h00}) begin
                $display("FAIL rr_idle_k%0d got busy=%b sel=%0d grant=%h exp busy=0 sel=%0d grant=00",
                         k, busy, sel, grant, exp_sel);
            end else pass_cnt++;
            tick();
        end
    endtask

    // MIN_HOLD=4 with done held high: 4 cycles granted, 2 cycles idle.
    task automatic test_min_hold();
        logic [7:0] exp_gnt;
        do_reset();
        enable = 1'b1;
        req4   = 8'h01;
        done4  = 1'b1;
        tick();
        for (int c = 0; c < 18; c++) begin
            exp_gnt = ((c % 6) < 4) ? 8'h01 : 8'h00;
            total_cnt++;
            if (grant4 !== exp_gnt) begin
                $display("FAIL min_hold_c%0d got grant=%h exp %h", c, grant4, exp_gnt);
            end else pass_cnt++;
            tick();
        end
        req4  = 8'h00;
        done4 = 1'b0;
    endtask

    // A done pulse before MIN_HOLD is met is lost. Dropping req releases.
    task automatic test_early_done();
        do_reset();
        enable = 1'b1;
        req    = 8'h01;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            total_cnt++;
            if ({busy, grant} !== {1'b1, 8'h01}) begin
                $display("FAIL early_done_c%0d got busy=%b grant=%h exp busy=1 grant=01", c, busy, grant);
            end else pass_cnt++;
            tick();
        end
        req = 8'h00;
        tick();
        total_cnt++;
        if ({busy, grant} !== 9'd0) begin
            $display("FAIL req_drop_release got busy=%b grant=%h exp 0", busy, grant);
        end else pass_cnt++;
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable = 1'b1;
        req    = 8'h08;
        tick();
        enable = 1'b0;
        for (int h = 1; h <= 5; h++) begin
            total_cnt++;
            if ({busy, sel, grant} !== {1'b1, 3'd3, 8'h08}) begin
                $display("FAIL en_drop_h%0d got busy=%b sel=%0d grant=%h exp busy=1 sel=3 grant=08",
                         h, busy, sel, grant);
            end else pass_cnt++;
            if (h == 5) done = 1'b1;
            tick();
        end
        done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total_cnt++;
            if ({busy, sel, grant} !== {1'b0, 3'd3, 8'h00}) begin
                $display("FAIL en_off_c%0d got busy=%b sel=%0d grant=%h exp busy=0 sel=3 grant=00",
                         c, busy, sel, grant);
            end else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        enable = 1'b1;
        req    = 8'h40;
        tick();
        total_cnt++;
        if ({busy, sel, grant} !== {1'b1, 3'd6, 8'h40}) begin
            $display("FAIL pre_reset_grant got busy=%b sel=%0d grant=%h exp busy=1 sel=6 grant=40",
                     busy, sel, grant);
        end else pass_cnt++;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, grant} !== 9'd0) begin
            $display("FAIL async_reset got busy=%b grant=%h exp 0", busy, grant);
        end else pass_cnt++;
        req   = 8'hFF;
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if ({busy, sel, grant} !== {1'b1, 3'd0, 8'h01}) begin
            $display("FAIL post_reset_first got busy=%b sel=%0d grant=%h exp busy=1 sel=0 grant=01",
                     busy, sel, grant);
        end else pass_cnt++;
    endtask

    // All 8 requesting with done held high: order 0..7 then back to 0.
    task automatic test_back_to_back();
        logic [7:0] exp_gnt;
        do_reset();
        enable = 1'b1;
        req    = 8'hFF;
        done   = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            exp_gnt = 8'd1 << (k % 8);
            total_cnt++;
            if (grant !== exp_gnt) begin
                $display("FAIL fair_k%0d got grant=%h exp %h", k, grant, exp_gnt);
            end else pass_cnt++;
            tick();
            tick();
            total_cnt++;
            if (grant !== 8'h00) begin
                $display("FAIL fair_gap_k%0d got grant=%h exp 00", k, grant);
            end else pass_cnt++;
            tick();
            tick();
        end
        done = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset();
        enable = 1'b1;
        req    = 8'h80;
        tick();
`ifdef WATCHDOG_EN
        for (int h = 1; h <= 9; h++) begin
            total_cnt++;
            if ({busy, grant, timeout} !== {1'b1, 8'h80, 1'b0}) begin
                $display("FAIL wd_hold_h%0d got busy=%b grant=%h timeout=%b exp busy=1 grant=80 timeout=0",
                         h, busy, grant, timeout);
            end else pass_cnt++;
            tick();
        end
        total_cnt++;
        if ({busy, grant, timeout} !== {1'b0, 8'h00, 1'b1}) begin
            $display("FAIL wd_fire got busy=%b grant=%h timeout=%b exp busy=0 grant=00 timeout=1",
                     busy, grant, timeout);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if ({grant, timeout} !== 9'd0) begin
            $display("FAIL wd_idle got grant=%h timeout=%b exp 0", grant, timeout);
        end else pass_cnt++;
        tick();
        total_cnt++;
        if (grant !== 8'h80) begin
            $display("FAIL wd_regrant got grant=%h exp 80", grant);
        end else pass_cnt++;
`else
        for (int h = 1; h <= 20; h++) begin
            total_cnt++;
            if ({busy, grant, timeout} !== {1'b1, 8'h80, 1'b0}) begin
                $display("FAIL nowd_hold_h%0d got busy=%b grant=%h timeout=%b exp busy=1 grant=80 timeout=0",
                         h, busy, grant, timeout);
            end else pass_cnt++;
            tick();
        end
`endif
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        req    = 8'h00;
        done   = 1'b0;
        req4   = 8'h00;
        done4  = 1'b0;
        test_reset();
        test_idle();
        test_round_robin_pair();
        test_min_hold();
        test_early_done();
        test_enable_drop();
        test_reset_mid_grant();
        test_back_to_back();
        test_watchdog();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
